// File: rtl/ppe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ppe_pkg
// Brief    : Shared FSM state type and pointer-wrap helper for the PPE arbiter.
// Revision : 1.0
// ============================================================================
package ppe_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } ppe_state_t;

    // Wrap is explicit at width-1 so non-power-of-two widths work.
    function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned width);
        return (idx == width - 1) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ppe_find_first.sv
`default_nettype none
// ============================================================================
// Module   : ppe_find_first
// Brief    : Combinational find-first-set (lowest index) with binary and one-hot outputs.
// Revision : 1.0
// ============================================================================
module ppe_find_first
    import ppe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LOG_W = 3
) (
    input  logic [WIDTH-1:0] vec,
    output logic             found,
    output logic [LOG_W-1:0] idx,
    output logic [WIDTH-1:0] onehot
);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        idx    = '0;
        onehot = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx       = LOG_W'(i);
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

    assign found = |vec;

endmodule
`default_nettype wire

// File: rtl/rr_ppe_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_ppe_arbiter
// Brief    : Round-robin arbiter with registered, backpressure-held grant.
// Revision : 1.0
// ============================================================================
module rr_ppe_arbiter
    import ppe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LOG_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    input  logic             ptr_load,
    input  logic [LOG_W-1:0] ptr_value,
    output logic             gnt_valid,
    input  logic             gnt_ready,
    output logic [LOG_W-1:0] gnt_idx,
    output logic [WIDTH-1:0] gnt_oh,
    output logic [LOG_W-1:0] ptr
);

    ppe_state_t       r_state;
    logic             r_gnt_valid;
    logic [LOG_W-1:0] r_gnt_idx;
    logic [WIDTH-1:0] r_gnt_oh;
    logic [LOG_W-1:0] r_ptr;

    logic             w_accept;
    logic [LOG_W-1:0] w_adv_ptr;
    logic [LOG_W-1:0] w_search_ptr;
    logic [WIDTH-1:0] w_mask;
    logic             w_m_found;
    logic [LOG_W-1:0] w_m_idx;
    logic [WIDTH-1:0] w_m_oh;
    logic             w_u_found;
    logic [LOG_W-1:0] w_u_idx;
    logic [WIDTH-1:0] w_u_oh;
    logic [LOG_W-1:0] w_win_idx;
    logic [WIDTH-1:0] w_win_oh;

    assign w_accept  = r_gnt_valid & gnt_ready;
    assign w_adv_ptr = LOG_W'(next_ptr(32'(r_gnt_idx), WIDTH));

    // A load always takes priority; in GRANT the search only matters on accept.
    assign w_search_ptr = ptr_load              ? ptr_value :
                          (r_state == ST_GRANT) ? w_adv_ptr : r_ptr;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
        assign w_mask[gi] = (LOG_W'(gi) >= w_search_ptr);
    end

    ppe_find_first #(.WIDTH(WIDTH), .LOG_W(LOG_W)) u_masked (
        .vec    (req & w_mask),
        .found  (w_m_found),
        .idx    (w_m_idx),
        .onehot (w_m_oh)
    );

    ppe_find_first #(.WIDTH(WIDTH), .LOG_W(LOG_W)) u_unmasked (
        .vec    (req),
        .found  (w_u_found),
        .idx    (w_u_idx),
        .onehot (w_u_oh)
    );

    assign w_win_idx = w_m_found ? w_m_idx : w_u_idx;
    assign w_win_oh  = w_m_found ? w_m_oh  : w_u_oh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_gnt_valid <= 1'b0;
            r_gnt_idx   <= '0;
            r_gnt_oh    <= '0;
            r_ptr       <= '0;
        end else begin
            if (ptr_load) begin
                r_ptr <= ptr_value;
            end else if (w_accept) begin
                r_ptr <= w_adv_ptr;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_u_found) begin
                        r_gnt_idx   <= w_win_idx;
                        r_gnt_oh    <= w_win_oh;
                        r_gnt_valid <= 1'b1;
                        r_state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_accept) begin
                        if (w_u_found) begin
                            r_gnt_idx <= w_win_idx;
                            r_gnt_oh  <= w_win_oh;
                        end else begin
                            r_gnt_valid <= 1'b0;
                            r_gnt_oh    <= '0;
                            r_state     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_gnt_valid <= 1'b0;
                    r_gnt_oh    <= '0;
                end
            endcase
        end
    end

    assign gnt_valid = r_gnt_valid;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_oh    = r_gnt_oh;
    assign ptr       = r_ptr;

endmodule
`default_nettype wire

// File: tb/tb_rr_ppe_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_ppe_arbiter
// Brief    : Directed-vector and random reference-model bench for rr_ppe_arbiter.
// Revision : 1.0
// ============================================================================
module tb_rr_ppe_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = '0;
    logic       ptr_load = 1'b0;
    logic [2:0] ptr_value = '0;
    logic       gnt_valid;
    logic       gnt_ready = 1'b0;
    logic [2:0] gnt_idx;
    logic [7:0] gnt_oh;
    logic [2:0] ptr;

    int n_vec = 0;
    int n_err = 0;

    rr_ppe_arbiter #(.WIDTH(8), .LOG_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .ptr_load  (ptr_load),
        .ptr_value (ptr_value),
        .gnt_valid (gnt_valid),
        .gnt_ready (gnt_ready),
        .gnt_idx   (gnt_idx),
        .gnt_oh    (gnt_oh),
        .ptr       (ptr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic       rdy;
        logic       ld;
        logic [2:0] pv;
        logic       ev;
        logic [2:0] ei;
        logic [7:0] eo;
        logic [2:0] ep;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [7:0] r, input logic rd, input logic l, input logic [2:0] p,
                       input logic v, input logic [2:0] i, input logic [7:0] o, input logic [2:0] pt);
        vec_t e;
        e = '{req: r, rdy: rd, ld: l, pv: p, ev: v, ei: i, eo: o, ep: pt};
        tbl.push_back(e);
    endtask

    task automatic check(input string name, input logic ev, input logic [2:0] ei,
                         input logic [7:0] eo, input logic [2:0] ep);
        n_vec++;
        if (gnt_valid !== ev || gnt_oh !== eo || ptr !== ep || (ev && gnt_idx !== ei)) begin
            n_err++;
            $display("FAIL %s: got valid=%b idx=%0d oh=%h ptr=%0d, want valid=%b idx=%0d oh=%h ptr=%0d",
                     name, gnt_valid, gnt_idx, gnt_oh, ptr, ev, ei, eo, ep);
        end
    endtask

    // Reference: rotate from the pointer and take the first request found.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] j;
        for (int k = 0; k < 8; k++) begin
            j = p + 3'(k);
            if (r[j]) return j;
        end
        return 3'd0;
    endfunction

    logic       m_valid;
    logic [2:0] m_idx;
    logic [2:0] m_ptr;
    int         m_wait [8];

    task automatic model_reset();
        m_valid = 1'b0;
        m_idx   = '0;
        m_ptr   = '0;
        for (int i = 0; i < 8; i++) m_wait[i] = 0;
    endtask

    task automatic model_edge();
        logic       acc;
        logic [2:0] np;
        logic [2:0] sp;
        acc = m_valid & gnt_ready;
        np  = (m_idx == 3'd7) ? 3'd0 : m_idx + 3'd1;
        for (int i = 0; i < 8; i++) begin
            if (!req[i] || ptr_load) m_wait[i] = 0;
            else if (acc && m_idx == 3'(i)) m_wait[i] = 0;
            else if (acc) m_wait[i]++;
        end
        if (!m_valid) begin
            sp = ptr_load ? ptr_value : m_ptr;
            if (|req) begin
                m_valid = 1'b1;
                m_idx   = rr_pick(req, sp);
            end
        end else if (acc) begin
            sp = ptr_load ? ptr_value : np;
            if (|req) m_idx = rr_pick(req, sp);
            else      m_valid = 1'b0;
        end
        if (ptr_load) m_ptr = ptr_value;
        else if (acc) m_ptr = np;
    endtask

    initial begin
        // Directed table; each row is one clock and the state expected after it.
        // Walk three requesters with back-to-back accepts.
        add(8'hA4, 1, 0, 0, 1, 2, 8'h04, 0);
        add(8'hA4, 1, 0, 0, 1, 5, 8'h20, 3);
        add(8'hA4, 1, 0, 0, 1, 7, 8'h80, 6);
        add(8'hA4, 1, 0, 0, 1, 2, 8'h04, 0);
        add(8'hA4, 1, 0, 0, 1, 5, 8'h20, 3);
        add(8'h00, 1, 0, 0, 0, 0, 8'h00, 6);
        // Grant held under backpressure while req changes.
        add(8'h10, 0, 0, 0, 1, 4, 8'h10, 6);
        add(8'h10, 0, 0, 0, 1, 4, 8'h10, 6);
        add(8'h10, 0, 0, 0, 1, 4, 8'h10, 6);
        add(8'h01, 0, 0, 0, 1, 4, 8'h10, 6);
        add(8'h01, 1, 0, 0, 1, 0, 8'h01, 5);
        add(8'h00, 1, 0, 0, 0, 0, 8'h00, 1);
        // Load in IDLE steers the same-cycle search; accept then wraps.
        add(8'h41, 0, 1, 6, 1, 6, 8'h40, 6);
        add(8'h41, 1, 0, 0, 1, 0, 8'h01, 7);
        add(8'h00, 1, 0, 0, 0, 0, 8'h00, 1);
        // Load coincident with accept overrides the advanced pointer.
        add(8'h0A, 0, 1, 2, 1, 3, 8'h08, 2);
        add(8'h0A, 1, 1, 1, 1, 1, 8'h02, 1);
        add(8'h00, 1, 0, 0, 0, 0, 8'h00, 2);
        // Ready with no grant is ignored.
        add(8'h00, 1, 0, 0, 0, 0, 8'h00, 2);
        // Load during GRANT leaves the held grant alone.
        add(8'h0A, 0, 0, 0, 1, 3, 8'h08, 2);
        add(8'h0A, 0, 1, 5, 1, 3, 8'h08, 5);
        add(8'h0A, 1, 0, 0, 1, 1, 8'h02, 4);
        add(8'h00, 1, 0, 0, 0, 0, 8'h00, 2);

        rst = 1'b1;
        #12;
        check("reset", 1'b0, 3'd0, 8'h00, 3'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < tbl.size(); v++) begin
            @(negedge clk);
            req       = tbl[v].req;
            gnt_ready = tbl[v].rdy;
            ptr_load  = tbl[v].ld;
            ptr_value = tbl[v].pv;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", v), tbl[v].ev, tbl[v].ei, tbl[v].eo, tbl[v].ep);
        end

        // Async reset mid-grant, between clock edges.
        @(negedge clk);
        req = 8'hA4; gnt_ready = 1'b0; ptr_load = 1'b0; ptr_value = 3'd0;
        @(posedge clk); #1;
        check("pre_rst_grant", 1'b1, 3'd2, 8'h04, 3'd2);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", 1'b0, 3'd0, 8'h00, 3'd0);
        @(negedge clk);
        req = 8'h00;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_idle", 1'b0, 3'd0, 8'h00, 3'd0);

        // Random traffic against the reference model.
        model_reset();
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            if ($urandom_range(3) == 0) req = 8'($urandom);
            gnt_ready = ($urandom_range(2) != 0);
            ptr_load  = ($urandom_range(15) == 0);
            ptr_value = 3'($urandom);
            @(posedge clk);
            model_edge();
            #1;
            check($sformatf("rand%0d", c), m_valid, m_idx, m_valid ? (8'h01 << m_idx) : 8'h00, m_ptr);
            n_vec++;
            for (int i = 0; i < 8; i++) begin
                if (m_wait[i] > 8) begin
                    n_err++;
                    $display("FAIL starve%0d: req %0d waited %0d accepts, limit 8", c, i, m_wait[i]);
                    m_wait[i] = 0;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
